bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for the shared packet bus between drvrs terminals.
//  Each terminal presents a first-word-fall-through input FIFO (pndng/D_pop/pop).
//  One packet at a time is popped, its destination ID is decoded from the top 8 bits,
//  and the packet is pushed to the destination terminal(s) over a single shared D_push bus.
// PARAMETERS
//  drvrs    4    number of terminals on the bus (2..16)
//  pckg_sz  16   packet width; ID = [pckg_sz-1 -: 8], payload = remaining LSBs
//  broadcast 8'hFF  ID value that delivers to every terminal except the source
// PORTS
//  clk      in   1               rising-edge clock
//  reset    in   1               synchronous, active-high reset
//  pndng    in   drvrs           terminal i FIFO non-empty
//  D_pop    in   drvrs*pckg_sz   head word of FIFO i at [i*pckg_sz +: pckg_sz]
//  pop      out  drvrs           one-hot 1-cycle pop strobe to the granted FIFO
//  push     out  drvrs           push strobe(s) to destination terminal(s)
//  D_push   out  pckg_sz         shared bus data, valid while any push bit is high
//  busy     out  1               transfer in flight (state != IDLE)
//  gnt_id   out  $clog2(drvrs)   index of current/last granted source
//  drop_cnt out  16              count of dropped packets, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: pop=0, push=0, D_push=0, busy=0, gnt_id=0, drop_cnt=0, rr_ptr=0, state=IDLE.
//  Reset asserted mid-transfer aborts it: no pop/push on the cycle after reset; packet stays in FIFO
//   if pop not yet issued, otherwise it is lost (not counted as dropped).
//  All outputs are registered. FSM, one transfer per 3 cycles:
//   IDLE:    if |pndng: winner = first set bit at or after rr_ptr (wrapping drvrs-1 -> 0);
//            latch data_r = D_pop[winner], gnt_id = winner; -> POP. Else stay IDLE.
//   POP:     pop[gnt_id]=1 for exactly this cycle; decode data_r ID; -> DELIVER.
//   DELIVER: ID < drvrs and ID != gnt_id -> push[ID]=1, D_push=data_r.
//            ID == broadcast -> push = all ones except bit gnt_id, D_push=data_r.
//            ID == gnt_id, or ID >= drvrs and != broadcast -> no push, drop_cnt += 1 (sat).
//            rr_ptr = gnt_id+1 (mod drvrs); -> IDLE.
//  Latency: pndng high at edge N (IDLE) -> pop at cycle N+1 -> push/D_push at N+2.
//  Fairness: a continuously pending terminal is granted at least once every drvrs transfers.
//  pndng deasserting after grant is ignored; pop is still issued (FIFO must tolerate it).
//  pndng changing in POP/DELIVER has no effect until the next IDLE.
//  D_push holds last value when push=0; push is a single-cycle strobe.
// CONFIGURATION
//  BUS_ARB_PKT_CNT_EN defined: adds output pkt_cnt [drvrs*16], per-source count of
//   successfully delivered packets (broadcast counts once), 16-bit saturating, cleared on reset.
//  Not defined: port and counters absent; all other behaviour identical.
// TESTING (drvrs=4, pckg_sz=16)
//  1 reset=1 for 2 cycles with pndng=4'hF -> pop=0, push=0, busy=0, drop_cnt=0 throughout.
//  2 pndng[1]=1, D_pop[1]=16'h0202 -> pop=4'b0010 at N+1, push=4'b0100, D_push=16'h0202 at N+2.
//  3 pndng=4'hF, each FIFO holds 2 words -> grant order 0,1,2,3,0,1,2,3; 8 transfers in 24 cycles.
//  4 pndng[3]=1, D_pop[3]=16'hFF07 -> push=4'b0111, D_push=16'hFF07; no push to terminal 3.
//  5 D_pop[0]=16'h0007 (self) then 16'h0907 (ID 9) -> no push either time, drop_cnt=2.
//  6 reset pulse during POP state -> next cycle pop=0, push=0, state IDLE, rr_ptr=0;
//    with BUS_ARB_PKT_CNT_EN, scenario 3 ends with pkt_cnt = {4{16'd2}}.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: terminal FIFO pop side and shared push bus of the packet arbiter
interface bus_rr_arbiter_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [pckg_sz-1:0]       D_push;
    modport master (input pndng, D_pop, output pop, push, D_push);
    modport slave (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin packet sequencer, IDLE->POP->DELIVER; BUS_ARB_PKT_CNT_EN adds per-source delivered counters
module bus_rr_arbiter #(
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    localparam int         W         = $clog2(drvrs)
) (
    input  logic               clk,
    input  logic               reset,
    bus_rr_arbiter_if.master   bus,
    output logic               busy,
    output logic [W-1:0]       gnt_id,
    output logic [15:0]        drop_cnt
`ifdef BUS_ARB_PKT_CNT_EN
    ,
    output logic [drvrs*16-1:0] pkt_cnt
`endif
);
    localparam logic [1:0]       IDLE    = 2'd0;
    localparam logic [1:0]       POP     = 2'd1;
    localparam logic [1:0]       DELIVER = 2'd2;
    localparam logic [7:0]       NDRV    = 8'(drvrs);
    localparam logic [W-1:0]     LAST    = W'(drvrs - 1);
    localparam logic [drvrs-1:0] ONE     = {{(drvrs-1){1'b0}}, 1'b1};
    logic [1:0]         state;
    logic [W-1:0]       rr_ptr;
    logic [W-1:0]       win;
    logic [pckg_sz-1:0] data_r;
    logic [7:0]         id;
    logic [drvrs-1:0]   src_oh;
    logic [drvrs-1:0]   dst_mask;
    logic               deliver_ok;
    // first requester at or after ptr; scanning downwards lets the nearest one win
    function automatic logic [W-1:0] pick(input logic [drvrs-1:0] req, input logic [W-1:0] ptr);
        logic [W-1:0] r;
        int j;
        r = ptr;
        for (int k = drvrs - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= drvrs) j = j - drvrs;
            if (req[j]) r = W'(j);
        end
        return r;
    endfunction
    // grant selection and destination decode of the latched packet
    always_comb begin
        win        = pick(bus.pndng, rr_ptr);
        id         = data_r[pckg_sz-1 -: 8];
        src_oh     = ONE << gnt_id;
        dst_mask   = (id == broadcast) ? ~src_oh :
                     (id < NDRV && id != 8'(gnt_id)) ? ONE << id[W-1:0] : '0;
        deliver_ok = |dst_mask;
    end
    // transfer sequencer: grant/latch, pop strobe, then push or drop
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_id     <= '0;
            data_r     <= '0;
            busy       <= 1'b0;
            drop_cnt   <= '0;
            bus.pop    <= '0;
            bus.push   <= '0;
            bus.D_push <= '0;
        end else begin
            bus.pop  <= '0;
            bus.push <= '0;
            if (state == IDLE) begin
                if (|bus.pndng) begin
                    gnt_id  <= win;
                    data_r  <= bus.D_pop[win*pckg_sz +: pckg_sz];
                    bus.pop <= ONE << win;
                    busy    <= 1'b1;
                    state   <= POP;
                end
            end else if (state == POP) begin
                bus.push <= dst_mask;
                if (deliver_ok) bus.D_push <= data_r;
                else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                state <= DELIVER;
            end else begin
                rr_ptr <= (gnt_id == LAST) ? '0 : gnt_id + W'(1);
                busy   <= 1'b0;
                state  <= IDLE;
            end
        end
    end
`ifdef BUS_ARB_PKT_CNT_EN
    // per-source delivered packet counters, broadcast counted once
    always_ff @(posedge clk) begin
        if (reset) pkt_cnt <= '0;
        else if (state == POP && deliver_ok && pkt_cnt[gnt_id*16 +: 16] != 16'hFFFF)
            pkt_cnt[gnt_id*16 +: 16] <= pkt_cnt[gnt_id*16 +: 16] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: queue-backed FIFOs, transaction-level reference model and scoreboard monitor
module tb_bus_rr_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    bus_rr_arbiter_if #(.drvrs(N), .pckg_sz(16)) bus();
    logic        busy;
    logic [1:0]  gnt_id;
    logic [15:0] drop_cnt;
`ifdef BUS_ARB_PKT_CNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif
    bus_rr_arbiter #(.drvrs(N), .pckg_sz(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .gnt_id(gnt_id), .drop_cnt(drop_cnt)
`ifdef BUS_ARB_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );
    typedef struct {int c; int w;} pop_t;
    typedef struct {int c; logic [N-1:0] m; logic [15:0] d;} push_t;
    int total = 0, bad = 0, cyc = 0;
    logic [15:0] tq [N][$];
    logic [15:0] mq [N][$];
    pop_t  exp_pop[$], glog[$];
    push_t exp_push[$];
    int rr = 0, cnt = 0, m_drops = 0;
    int m_pk [N];
    logic [N-1:0] last_mask = '0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    // reference: a transfer starts every third cycle at most, winner is first non-empty FIFO from rr
    always @(posedge clk) begin
        int w;
        logic [15:0] d;
        logic [7:0] id;
        logic [N-1:0] m;
        cyc++;
        if (reset) begin
            rr = 0; cnt = 0; m_drops = 0;
            exp_pop.delete(); exp_push.delete();
            for (int i = 0; i < N; i++) m_pk[i] = 0;
        end else if (cnt > 0) cnt--;
        else begin
            w = -1;
            for (int k = 0; k < N; k++) if (w < 0 && mq[(rr + k) % N].size() > 0) w = (rr + k) % N;
            if (w >= 0) begin
                d = mq[w].pop_front();
                id = d[15:8];
                if (id == 8'hFF) m = 4'hF & ~(4'b1 << w);
                else if (int'(id) < N && int'(id) != w) m = 4'b1 << id;
                else m = 4'b0;
                exp_pop.push_back('{cyc, w});
                if (m != 0) begin
                    exp_push.push_back('{cyc + 1, m, d});
                    m_pk[w]++;
                end else m_drops++;
                rr = (w + 1) % N;
                cnt = 2;
            end
        end
    end
    // scoreboard monitor: compares every pop and push the DUT presents
    always @(negedge clk) begin
        pop_t e;
        push_t p;
        if (bus.pop != 0) begin
            glog.push_back('{cyc, int'(gnt_id)});
            if (exp_pop.size() == 0) chk("pop_unexpected", 64'(bus.pop), 0);
            else begin
                e = exp_pop.pop_front();
                chk("pop_onehot", 64'(bus.pop), 64'(4'b1 << e.w));
                chk("pop_cycle", 64'(cyc), 64'(e.c));
                chk("gnt_id", 64'(gnt_id), 64'(e.w));
                chk("busy_pop", 64'(busy), 1);
            end
        end
        if (bus.push != 0) begin
            last_mask = bus.push;
            if (exp_push.size() == 0) chk("push_unexpected", 64'(bus.push), 0);
            else begin
                p = exp_push.pop_front();
                chk("push_mask", 64'(bus.push), 64'(p.m));
                chk("push_data", 64'(bus.D_push), 64'(p.d));
                chk("push_cycle", 64'(cyc), 64'(p.c));
                chk("busy_push", 64'(busy), 1);
            end
        end
    end
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.pndng[i] = tq[i].size() > 0;
            bus.D_pop[i*16 +: 16] = tq[i].size() > 0 ? tq[i][0] : 16'h0;
        end
    endtask
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (bus.pop[i] && tq[i].size() > 0) void'(tq[i].pop_front());
        drive();
    endtask
    task automatic add(int i, logic [15:0] d);
        tq[i].push_back(d);
        mq[i].push_back(d);
        drive();
    endtask
    function automatic bit idle();
        bit r = exp_pop.size() == 0 && exp_push.size() == 0 && !busy && cnt == 0;
        for (int i = 0; i < N; i++) if (tq[i].size() > 0) r = 0;
        return r;
    endfunction
    task automatic drain(string nm);
        int n = 0;
        while (n < 300 && !idle()) begin
            step();
            n++;
        end
        chk({nm, "_drain"}, 64'(n < 300), 1);
        step();
    endtask
    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        glog.delete();
    endtask
    function automatic logic [63:0] model_pk();
        logic [63:0] r = '0;
        for (int i = 0; i < N; i++) r[i*16 +: 16] = 16'(m_pk[i]);
        return r;
    endfunction
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    // directed scenarios, then a randomized run against the model
    initial begin
        int n;
        bus.pndng = '0;
        bus.D_pop = '0;
        for (int i = 0; i < N; i++) add(i, {8'((i + 1) % N), 8'(i)});
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_pop", 64'(bus.pop), 0);
            chk("rst_push", 64'(bus.push), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_drop", 64'(drop_cnt), 0);
            chk("rst_gnt", 64'(gnt_id), 0);
        end
        reset = 1'b0;
        drain("s1");
        pulse_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) add(i, {8'((i + 1) % N), 8'(16 * r + i)});
        drain("s3");
        chk("s3_count", 64'(glog.size()), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("s3_order", 64'(glog[k].w), 64'(k % N));
        if (glog.size() == 8) chk("s3_span", 64'(glog[7].c - glog[0].c), 21);
`ifdef BUS_ARB_PKT_CNT_EN
        chk("s3_pkt_cnt", 64'(pkt_cnt), {4{16'd2}});
`endif
        add(1, 16'h0202);
        drain("s2");
        chk("s2_last_mask", 64'(last_mask), 64'(4'b0100));
        chk("s2_hold_push", 64'(bus.push), 0);
        chk("s2_hold_data", 64'(bus.D_push), 64'h0202);
        pulse_reset();
        add(0, 16'h0007);
        add(0, 16'h0907);
        drain("s5");
        chk("s5_drop", 64'(drop_cnt), 2);
        add(2, 16'h0100);
        n = 0;
        while (n < 20 && bus.pop == 0) begin
            step();
            n++;
        end
        chk("s6_pop_seen", 64'(n < 20), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s6_pop", 64'(bus.pop), 0);
        chk("s6_push", 64'(bus.push), 0);
        chk("s6_busy", 64'(busy), 0);
        glog.delete();
        add(0, 16'h0100);
        add(1, 16'h0000);
        drain("s6");
        chk("s6_rr", glog.size() > 0 ? 64'(glog[0].w) : 64'hFF, 0);
        add(3, 16'hFF07);
        drain("s4");
        chk("s4_mask", 64'(last_mask), 64'(4'b0111));
        for (int k = 0; k < 60; k++) begin
            int sel = $urandom_range(0, 5);
            logic [7:0] id = sel < 4 ? 8'(sel) : sel == 4 ? 8'hFF : 8'($urandom_range(4, 254));
            add($urandom_range(0, N - 1), {id, 8'($urandom)});
            n = $urandom_range(0, 4);
            for (int s = 0; s < n; s++) step();
        end
        drain("rand");
        chk("final_drop", 64'(drop_cnt), 64'(m_drops));
`ifdef BUS_ARB_PKT_CNT_EN
        chk("final_pkt_cnt", 64'(pkt_cnt), model_pk());
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
